// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types, widths and helpers for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================

// Platform-wide widths; normally provided by the system defines header.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h8000_0000
`endif

package ifetch_pkg;

   localparam int INSTR_W = 32;

   // One decoded-side entry: the fetched word together with its PC.
   typedef struct packed {
      logic [`XLEN-1:0]   pc;
      logic [INSTR_W-1:0] instr;
   } ifetch_entry_t;

   // Width of a counter that must hold every value 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mod_ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mod_sync_fifo
// Purpose  : Small synchronous FIFO with single-cycle flush. Head is visible
//            combinationally; flush dominates push and pop in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================

module mod_sync_fifo
   import ifetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic [cnt_width(DEPTH)-1:0]  count_o
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_do_push;
   logic             w_do_pop;

   // Next-state pointers, occupancy and storage; a push into a full FIFO is
   // only honoured when the head leaves in the same cycle.
   always_comb begin
      w_do_pop  = pop_i & (count_q != '0);
      w_do_push = push_i & ((count_q < CW'(DEPTH)) | w_do_pop);
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (w_do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PW'(1);
         end
         if (w_do_pop) begin
            rptr_d = rptr_q + PW'(1);
         end
         count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mod_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : mod_ifetch
// Purpose  : Instruction fetch unit. Issues in-order word requests against the
//            PC register, tags them with their PC, buffers responses and hands
//            {pc, instr} to decode. A redirect flushes the buffer and drops
//            every response still in flight.
// Revision : 1.0 - initial release
// ============================================================================

module mod_ifetch
   import ifetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [`XLEN-1:0]   pc_i,
   input  logic               pc_stb_i,
   output logic               stall_o,
   output logic               imem_req_o,
   output logic [`XLEN-1:0]   imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [`XLEN-1:0]   instr_pc_o,
   input  logic               instr_ready_i
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int SW = CW + 1;
   localparam int EW = $bits(ifetch_entry_t);

   logic [CW-1:0]    outstanding_q, outstanding_d;
   logic [CW-1:0]    discard_q, discard_d;
   ifetch_entry_t    last_q, last_d;

   logic [CW-1:0]    w_fcount;
   logic [CW-1:0]    w_unused_tag_count;
   logic [1:0]       w_unused_pc_lsb;
   logic [`XLEN-1:0] w_tag_head;
   logic [EW-1:0]    w_head_bits;
   ifetch_entry_t    w_head;
   ifetch_entry_t    w_push_entry;
   logic [SW-1:0]    w_committed;
   logic             w_credit;
   logic             w_req;
   logic             w_accept;
   logic             w_rsp_keep;
   logic             w_pop;

   // Issue/credit decisions from registered counters only; a redirect blocks
   // issue and swallows any response and decode pop in the same cycle.
   always_comb begin
      w_committed = ({1'b0, outstanding_q} - {1'b0, discard_q}) + {1'b0, w_fcount};
      w_credit    = (w_committed < SW'(FIFO_DEPTH)) && (outstanding_q < CW'(FIFO_DEPTH));
      w_req       = w_credit & ~pc_stb_i & rst_ni;
      w_accept    = w_req & imem_gnt_i;
      w_rsp_keep  = imem_rvalid_i & (discard_q == '0) & ~pc_stb_i;
      w_pop       = instr_valid_o & instr_ready_i & ~pc_stb_i;
   end

   // Outstanding/discard bookkeeping; a redirect marks every live request stale.
   always_comb begin
      outstanding_d = outstanding_q + CW'(w_accept) - CW'(imem_rvalid_i);
      discard_d     = discard_q;
      if (pc_stb_i) begin
         if (imem_rvalid_i && (outstanding_q != '0)) begin
            discard_d = outstanding_q - CW'(1);
         end else begin
            discard_d = outstanding_q;
         end
      end else if (imem_rvalid_i && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end
   end

   // Remember the last head shown so the outputs hold it while the buffer is empty.
   always_comb begin
      last_d = instr_valid_o ? w_head : last_q;
   end

   // Counters and held output entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         discard_q     <= '0;
         last_q        <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         last_q        <= last_d;
      end
   end

   // PCs of accepted requests, consumed in order by non-stale responses.
   mod_sync_fifo #(
      .WIDTH (`XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (pc_stb_i),
      .push_i  (w_accept),
      .data_i  (pc_i),
      .pop_i   (w_rsp_keep),
      .data_o  (w_tag_head),
      .count_o (w_unused_tag_count)
   );

   assign w_push_entry.pc    = w_tag_head;
   assign w_push_entry.instr = imem_rdata_i;

   // Instruction buffer feeding decode.
   mod_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (pc_stb_i),
      .push_i  (w_rsp_keep),
      .data_i  (w_push_entry),
      .pop_i   (w_pop),
      .data_o  (w_head_bits),
      .count_o (w_fcount)
   );

   assign w_head          = w_head_bits;
   assign w_unused_pc_lsb = pc_i[1:0];

   assign imem_req_o    = w_req;
   assign imem_addr_o   = {pc_i[`XLEN-1:2], 2'b00};
   assign stall_o       = ~w_accept;
   assign instr_valid_o = (w_fcount != '0);
   assign instr_o       = instr_valid_o ? w_head.instr : last_q.instr;
   assign instr_pc_o    = instr_valid_o ? w_head.pc    : last_q.pc;

   // A response can only come back for a request that is still in flight.
   a_rvalid_needs_outstanding : assert property (
      @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outstanding_q != '0));

endmodule

`default_nettype wire

// File: tb/tb_mod_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_ifetch
// Purpose  : Directed self-checking bench for mod_ifetch (FIFO_DEPTH = 2).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif

module tb_mod_ifetch;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [`XLEN-1:0]  pc_i;
   logic              pc_stb_i;
   logic              stall_o;
   logic              imem_req_o;
   logic [`XLEN-1:0]  imem_addr_o;
   logic              imem_gnt_i;
   logic              imem_rvalid_i;
   logic [31:0]       imem_rdata_i;
   logic              instr_valid_o;
   logic [31:0]       instr_o;
   logic [`XLEN-1:0]  instr_pc_o;
   logic              instr_ready_i;

   int checks = 0;
   int errors = 0;

   mod_ifetch #(.FIFO_DEPTH(2)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pc_i          (pc_i),
      .pc_stb_i      (pc_stb_i),
      .stall_o       (stall_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, then settle before checks.
   task automatic step(input logic stb, input logic [`XLEN-1:0] pc, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
      @(negedge clk_i);
      pc_stb_i      = stb;
      pc_i          = pc;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      instr_ready_i = rdy;
      #1;
   endtask

   initial begin
      rst_ni = 1'b0; pc_i = 32'h8000_0000; pc_stb_i = 1'b0; imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b1;

      // Reset values
      @(negedge clk_i); #1;
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", instr_pc_o, 0);
      chk("rst_req", imem_req_o, 0);
      chk("rst_stall", stall_o, 1);
      rst_ni = 1'b1;

      // Streaming fetch, gnt=1, rvalid one cycle after grant, ready=1
      step(0, 32'h8000_0000, 1, 0, 32'h0, 1);
      chk("c0_req", imem_req_o, 1);
      chk("c0_addr", imem_addr_o, 32'h8000_0000);
      chk("c0_stall", stall_o, 0);
      step(0, 32'h8000_0004, 1, 1, 32'hA000_0000, 1);
      chk("c1_addr", imem_addr_o, 32'h8000_0004);
      chk("c1_stall", stall_o, 0);
      chk("c1_valid", instr_valid_o, 0);
      step(0, 32'h8000_0008, 1, 1, 32'hA000_0001, 1);
      chk("c2_valid", instr_valid_o, 1);
      chk("c2_ipc", instr_pc_o, 32'h8000_0000);
      chk("c2_instr", instr_o, 32'hA000_0000);
      chk("c2_req_nocredit", imem_req_o, 0);
      chk("c2_stall", stall_o, 1);
      step(0, 32'h8000_0008, 1, 0, 32'h0, 1);
      chk("c3_ipc", instr_pc_o, 32'h8000_0004);
      chk("c3_instr", instr_o, 32'hA000_0001);
      chk("c3_addr", imem_addr_o, 32'h8000_0008);
      chk("c3_stall", stall_o, 0);
      step(0, 32'h8000_000C, 1, 1, 32'hA000_0002, 1);
      chk("c4_valid_empty", instr_valid_o, 0);
      chk("c4_hold_pc", instr_pc_o, 32'h8000_0004);
      chk("c4_hold_instr", instr_o, 32'hA000_0001);
      chk("c4_stall", stall_o, 0);

      // Decode stalled: buffer fills and issue stops
      step(0, 32'h8000_0010, 1, 1, 32'hA000_0003, 0);
      chk("c5_ipc", instr_pc_o, 32'h8000_0008);
      chk("c5_req", imem_req_o, 0);
      step(0, 32'h8000_0010, 1, 0, 32'h0, 0);
      chk("full_fcount", dut.w_fcount, 2);
      chk("full_req", imem_req_o, 0);
      chk("full_stall", stall_o, 1);
      step(0, 32'h8000_0010, 1, 0, 32'h0, 1);
      chk("pop_same_cycle_req", imem_req_o, 0);
      chk("pop_head", instr_pc_o, 32'h8000_0008);

      // Grant withheld for three cycles
      step(0, 32'h8000_0010, 0, 0, 32'h0, 0);
      chk("c8_req", imem_req_o, 1);
      chk("c8_head_pc", instr_pc_o, 32'h8000_000C);
      chk("c8_head_instr", instr_o, 32'hA000_0003);
      chk("c8_stall", stall_o, 1);
      step(0, 32'h8000_0010, 0, 0, 32'h0, 0);
      chk("c9_req", imem_req_o, 1);
      chk("c9_addr", imem_addr_o, 32'h8000_0010);
      chk("c9_stall", stall_o, 1);
      chk("c9_outst", dut.outstanding_q, 0);
      step(0, 32'h8000_0010, 0, 0, 32'h0, 0);
      chk("c10_addr", imem_addr_o, 32'h8000_0010);
      chk("c10_stall", stall_o, 1);
      step(0, 32'h8000_0010, 1, 0, 32'h0, 0);
      chk("c11_stall", stall_o, 0);
      step(0, 32'h8000_0014, 1, 1, 32'hA000_0004, 1);
      chk("c12_req", imem_req_o, 0);
      chk("c12_head", instr_pc_o, 32'h8000_000C);
      step(0, 32'h8000_0014, 1, 0, 32'h0, 1);
      chk("c13_head_pc", instr_pc_o, 32'h8000_0010);
      chk("c13_head_instr", instr_o, 32'hA000_0004);
      chk("c13_stall", stall_o, 0);

      // Redirect to 0x100 with one request in flight
      step(1, 32'h0000_0100, 1, 0, 32'h0, 1);
      chk("f1_req", imem_req_o, 0);
      chk("f1_stall", stall_o, 1);
      step(0, 32'h0000_0100, 1, 0, 32'h0, 1);
      chk("f1_discard", dut.discard_q, 1);
      chk("f1_valid", instr_valid_o, 0);
      chk("f1_addr", imem_addr_o, 32'h0000_0100);
      chk("f1_stall", stall_o, 0);
      step(0, 32'h0000_0104, 1, 1, 32'hDEAD_0000, 1);
      chk("c16_req", imem_req_o, 0);
      step(0, 32'h0000_0104, 1, 0, 32'h0, 1);
      chk("c17_valid_stale_dropped", instr_valid_o, 0);
      chk("c17_addr", imem_addr_o, 32'h0000_0104);
      chk("c17_stall", stall_o, 0);

      // Redirect to 0x200 with 0x100 and 0x104 outstanding
      step(1, 32'h0000_0200, 1, 0, 32'h0, 1);
      chk("f2_req", imem_req_o, 0);
      step(0, 32'h0000_0200, 1, 1, 32'hDEAD_0001, 1);
      chk("f2_discard", dut.discard_q, 2);
      chk("f2_fcount", dut.w_fcount, 0);
      chk("f2_req_full_outst", imem_req_o, 0);
      step(0, 32'h0000_0200, 1, 1, 32'hDEAD_0002, 1);
      chk("c20_valid", instr_valid_o, 0);
      chk("c20_addr", imem_addr_o, 32'h0000_0200);
      chk("c20_stall", stall_o, 0);
      step(0, 32'h0000_0204, 1, 1, 32'hB000_0200, 1);
      chk("c21_valid", instr_valid_o, 0);
      chk("c21_stall", stall_o, 0);
      step(0, 32'h0000_0208, 1, 0, 32'h0, 1);
      chk("f2_first_valid", instr_valid_o, 1);
      chk("f2_first_pc", instr_pc_o, 32'h0000_0200);
      chk("f2_first_instr", instr_o, 32'hB000_0200);

      // Redirect coincident with a response, one more outstanding
      step(0, 32'h0000_0208, 1, 0, 32'h0, 1);
      chk("c23_stall", stall_o, 0);
      step(1, 32'h0000_0300, 1, 1, 32'hDEAD_0204, 1);
      chk("f3_req", imem_req_o, 0);
      step(0, 32'h0000_0300, 1, 0, 32'h0, 1);
      chk("f3_discard", dut.discard_q, 1);
      chk("f3_valid", instr_valid_o, 0);
      chk("f3_addr", imem_addr_o, 32'h0000_0300);
      step(0, 32'h0000_0304, 1, 1, 32'hDEAD_0208, 1);
      chk("c26_valid", instr_valid_o, 0);
      step(0, 32'h0000_0304, 1, 1, 32'hC000_0300, 1);
      chk("c27_valid", instr_valid_o, 0);
      chk("c27_addr", imem_addr_o, 32'h0000_0304);
      step(0, 32'h0000_0308, 1, 0, 32'h0, 1);
      chk("f3_first_pc", instr_pc_o, 32'h0000_0300);
      chk("f3_first_instr", instr_o, 32'hC000_0300);

      // Asynchronous reset with two requests outstanding
      step(0, 32'h0000_0308, 1, 0, 32'h0, 1);
      chk("c29_stall", stall_o, 0);
      step(0, 32'h0000_030C, 1, 0, 32'h0, 1);
      chk("c30_outst", dut.outstanding_q, 2);
      chk("c30_hold_instr", instr_o, 32'hC000_0300);
      #2; rst_ni = 1'b0; #1;
      chk("arst_valid", instr_valid_o, 0);
      chk("arst_instr", instr_o, 0);
      chk("arst_pc", instr_pc_o, 0);
      chk("arst_req", imem_req_o, 0);
      chk("arst_stall", stall_o, 1);
      chk("arst_outst", dut.outstanding_q, 0);
      imem_gnt_i = 1'b0;
      @(negedge clk_i); #1;
      rst_ni = 1'b1;
      step(0, 32'h8000_0000, 1, 0, 32'h0, 1);
      chk("post_valid", instr_valid_o, 0);
      chk("post_addr", imem_addr_o, 32'h8000_0000);
      chk("post_stall", stall_o, 0);
      step(0, 32'h8000_0004, 1, 1, 32'hE000_0000, 1);
      chk("post_valid2", instr_valid_o, 0);
      step(0, 32'h8000_0008, 0, 0, 32'h0, 1);
      chk("post_first_valid", instr_valid_o, 1);
      chk("post_first_pc", instr_pc_o, 32'h8000_0000);
      chk("post_first_instr", instr_o, 32'hE000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
